// File: rtl/dma_stream_unpacker.sv
// dma_stream_unpacker: routes tagged DMA words into per-channel FWFT FIFOs
// and serialises each stored word into OUT_W-bit lanes, LSB lane first.

// One channel: register FIFO plus lane sequencer on the lz/vz handshake.
module dma_stream_unpacker_ch #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [IN_W-1:0]  wdata,
  input  logic             vz,
  input  logic             clr,
  output logic             lz,
  output logic [OUT_W-1:0] data,
  output logic [LVL_W-1:0] level
);
  localparam int LANES = IN_W / OUT_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LN_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [LN_W-1:0]  lane;
  logic [OUT_W-1:0] lane_word;
  logic             xfer, pop;

  assign lz   = (level != '0) & ~clr;
  assign xfer = lz & vz;
  assign pop  = xfer & (lane == LN_W'(LANES - 1));
  assign data = lz ? lane_word : '0;

  // Head word is read straight from the array (first-word-fall-through).
  if (LANES == 1) begin : g_one
    assign lane_word = mem[rptr];
  end else begin : g_multi
    logic [LANES-1:0][OUT_W-1:0] head_l;
    assign head_l    = mem[rptr];
    assign lane_word = head_l[lane];
  end

  // Storage has no reset: a clear or reset only moves pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointer, level and lane state; clear overrides push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      lane  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      lane  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (xfer) begin
        if (pop) begin
          lane <= '0;
          rptr <= rptr + 1'b1;
        end else begin
          lane <= lane + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module dma_stream_unpacker #(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int DEPTH  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [IN_W-1:0]         s_data,
  input  logic [CH_W-1:0]         s_ch,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [NUM_CH*OUT_W-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_lz,
  input  logic [NUM_CH-1:0]       ch_vz,
  input  logic [NUM_CH-1:0]       clear_fifo,
  output logic [NUM_CH*LVL_W-1:0] fifo_level,
  output logic                    err_bad_ch,
  input  logic                    err_clr
);
  logic [NUM_CH-1:0][OUT_W-1:0] data_a;
  logic [NUM_CH-1:0][LVL_W-1:0] lvl_a;
  logic [NUM_CH-1:0]            push;
  logic                         ch_ok;

  assign ch_ok      = ({1'b0, s_ch} < (CH_W+1)'(NUM_CH));
  assign ch_data    = data_a;
  assign fifo_level = lvl_a;

  // Ready follows the addressed channel; unknown channels always sink.
  always_comb begin
    s_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (s_ch == CH_W'(i)) s_ready = (lvl_a[i] != LVL_W'(DEPTH)) & ~clear_fifo[i];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = s_valid & s_ready & ch_ok & (s_ch == CH_W'(i));
    dma_stream_unpacker_ch #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LVL_W(LVL_W)
    ) u_ch (
      .clk(clk), .reset_n(reset_n), .push(push[i]), .wdata(s_data),
      .vz(ch_vz[i]), .clr(clear_fifo[i]), .lz(ch_lz[i]),
      .data(data_a[i]), .level(lvl_a[i])
    );
  end

  // Sticky bad-channel flag; clear wins over a simultaneous set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      err_bad_ch <= 1'b0;
    else if (err_clr)                  err_bad_ch <= 1'b0;
    else if (s_valid & s_ready & ~ch_ok) err_bad_ch <= 1'b1;
  end
endmodule

// File: tb/tb_dma_stream_unpacker.sv
module tb_dma_stream_unpacker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 3 channels, 32->16, depth 16.
  logic [31:0] s_data = '0;
  logic [1:0]  s_ch = '0;
  logic        s_valid = 1'b0, s_ready, err_bad_ch, err_clr = 1'b0;
  logic [47:0] ch_data;
  logic [2:0]  ch_lz, ch_vz = '0, clear_fifo = '0;
  logic [14:0] fifo_level;

  dma_stream_unpacker dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_ch(s_ch), .s_valid(s_valid),
    .s_ready(s_ready), .ch_data(ch_data), .ch_lz(ch_lz), .ch_vz(ch_vz),
    .clear_fifo(clear_fifo), .fifo_level(fifo_level), .err_bad_ch(err_bad_ch),
    .err_clr(err_clr)
  );

  // Sweep instance A: 32->8, four lanes, single channel.
  logic [31:0] a_data = '0;
  logic [0:0]  a_ch = '0, a_lz, a_vz = '0, a_clr = '0;
  logic        a_valid = 1'b0, a_ready, a_err;
  logic [7:0]  a_out;
  logic [2:0]  a_lvl;
  dma_stream_unpacker #(.NUM_CH(1), .IN_W(32), .OUT_W(8), .DEPTH(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .s_data(a_data), .s_ch(a_ch), .s_valid(a_valid),
    .s_ready(a_ready), .ch_data(a_out), .ch_lz(a_lz), .ch_vz(a_vz),
    .clear_fifo(a_clr), .fifo_level(a_lvl), .err_bad_ch(a_err), .err_clr(1'b0)
  );

  // Sweep instance B: 32->32, one lane, single channel.
  logic [31:0] b_data = '0, b_out;
  logic [0:0]  b_ch = '0, b_lz, b_vz = '0, b_clr = '0;
  logic        b_valid = 1'b0, b_ready, b_err;
  logic [2:0]  b_lvl;
  dma_stream_unpacker #(.NUM_CH(1), .IN_W(32), .OUT_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .s_data(b_data), .s_ch(b_ch), .s_valid(b_valid),
    .s_ready(b_ready), .ch_data(b_out), .ch_lz(b_lz), .ch_vz(b_vz),
    .clear_fifo(b_clr), .fifo_level(b_lvl), .err_bad_ch(b_err), .err_clr(1'b0)
  );

  int n_pass = 0, n_chk = 0;

  function automatic logic [15:0] dat(int i); return ch_data[i*16 +: 16]; endfunction
  function automatic logic [4:0]  lvl(int i); return fifo_level[i*5 +: 5]; endfunction

  task automatic step(); @(posedge clk); #1; endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    s_ch = ch; s_data = d; s_valid = 1'b1; step(); s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (ch_lz !== 3'b0) $display("FAIL rst_lz got=%0h exp=0", ch_lz); else n_pass++;
    n_chk++; if (ch_data !== 48'b0) $display("FAIL rst_data got=%0h exp=0", ch_data); else n_pass++;
    n_chk++; if (fifo_level !== 15'b0) $display("FAIL rst_level got=%0h exp=0", fifo_level); else n_pass++;
    n_chk++; if (err_bad_ch !== 1'b0) $display("FAIL rst_err got=%0b exp=0", err_bad_ch); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", s_ready); else n_pass++;
    #4 reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ch_vz = 3'b111;
    push(2'd1, 32'hBEEF1234);
    n_chk++; if (ch_lz[1] !== 1'b1) $display("FAIL basic_lz got=%0b exp=1", ch_lz[1]); else n_pass++;
    n_chk++; if (dat(1) !== 16'h1234) $display("FAIL basic_lane0 got=%0h exp=1234", dat(1)); else n_pass++;
    step();
    n_chk++; if (dat(1) !== 16'hBEEF) $display("FAIL basic_lane1 got=%0h exp=beef", dat(1)); else n_pass++;
    step();
    n_chk++; if (ch_lz[1] !== 1'b0) $display("FAIL basic_lz_end got=%0b exp=0", ch_lz[1]); else n_pass++;
    n_chk++; if (lvl(1) !== 5'd0) $display("FAIL basic_level_end got=%0d exp=0", lvl(1)); else n_pass++;
    n_chk++; if (dat(1) !== 16'h0) $display("FAIL basic_data_zero got=%0h exp=0", dat(1)); else n_pass++;
    ch_vz = 3'b000;
  endtask

  task automatic test_full();
    for (int k = 0; k < 16; k++) push(2'd0, {16'hB000 + 16'(k), 16'hA000 + 16'(k)});
    n_chk++; if (lvl(0) !== 5'd16) $display("FAIL full_level got=%0d exp=16", lvl(0)); else n_pass++;
    s_ch = 2'd0; #1;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL full_ready0 got=%0b exp=0", s_ready); else n_pass++;
    s_ch = 2'd2; #1;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL full_ready2 got=%0b exp=1", s_ready); else n_pass++;
    // Offer a push while full: must be refused.
    s_ch = 2'd0; s_data = 32'hDEADDEAD; s_valid = 1'b1; step(); s_valid = 1'b0;
    n_chk++; if (lvl(0) !== 5'd16) $display("FAIL full_refuse got=%0d exp=16", lvl(0)); else n_pass++;
    ch_vz[0] = 1'b1; step(); step();
    n_chk++; if (lvl(0) !== 5'd15) $display("FAIL full_pop_level got=%0d exp=15", lvl(0)); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL full_ready_back got=%0b exp=1", s_ready); else n_pass++;
    for (int k = 1; k < 16; k++) begin
      n_chk++; if (dat(0) !== 16'hA000 + 16'(k)) $display("FAIL full_order_lo[%0d] got=%0h exp=%0h", k, dat(0), 16'hA000 + 16'(k)); else n_pass++;
      step();
      n_chk++; if (dat(0) !== 16'hB000 + 16'(k)) $display("FAIL full_order_hi[%0d] got=%0h exp=%0h", k, dat(0), 16'hB000 + 16'(k)); else n_pass++;
      step();
    end
    n_chk++; if (ch_lz[0] !== 1'b0) $display("FAIL full_drained got=%0b exp=0", ch_lz[0]); else n_pass++;
    ch_vz[0] = 1'b0;
  endtask

  task automatic test_push_pop();
    for (int k = 0; k < 5; k++) push(2'd1, {16'hD000 + 16'(k), 16'hC000 + 16'(k)});
    ch_vz[1] = 1'b1; step();
    n_chk++; if (dat(1) !== 16'hD000) $display("FAIL pp_lane1 got=%0h exp=d000", dat(1)); else n_pass++;
    push(2'd1, 32'hD005C005);
    ch_vz[1] = 1'b0;
    n_chk++; if (lvl(1) !== 5'd5) $display("FAIL pp_level got=%0d exp=5", lvl(1)); else n_pass++;
    n_chk++; if (dat(1) !== 16'hC001) $display("FAIL pp_next_lane0 got=%0h exp=c001", dat(1)); else n_pass++;
    clear_fifo[1] = 1'b1; step(); clear_fifo[1] = 1'b0;
    n_chk++; if (lvl(1) !== 5'd0) $display("FAIL pp_clear got=%0d exp=0", lvl(1)); else n_pass++;
  endtask

  task automatic test_clear();
    push(2'd2, 32'h22221111);
    ch_vz[2] = 1'b1; step(); ch_vz[2] = 1'b0;
    n_chk++; if (dat(2) !== 16'h2222) $display("FAIL clr_mid got=%0h exp=2222", dat(2)); else n_pass++;
    clear_fifo[2] = 1'b1; s_ch = 2'd2; s_data = 32'h44443333; s_valid = 1'b1; #1;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL clr_ready got=%0b exp=0", s_ready); else n_pass++;
    n_chk++; if (ch_lz[2] !== 1'b0) $display("FAIL clr_lz_comb got=%0b exp=0", ch_lz[2]); else n_pass++;
    step(); clear_fifo[2] = 1'b0; s_valid = 1'b0;
    n_chk++; if (lvl(2) !== 5'd0) $display("FAIL clr_level got=%0d exp=0", lvl(2)); else n_pass++;
    push(2'd2, 32'h66665555);
    n_chk++; if (dat(2) !== 16'h5555) $display("FAIL clr_restart got=%0h exp=5555", dat(2)); else n_pass++;
    n_chk++; if (lvl(2) !== 5'd1) $display("FAIL clr_restart_lvl got=%0d exp=1", lvl(2)); else n_pass++;
    ch_vz[2] = 1'b1; step(); step(); ch_vz[2] = 1'b0;
    n_chk++; if (ch_lz[2] !== 1'b0) $display("FAIL clr_drained got=%0b exp=0", ch_lz[2]); else n_pass++;
  endtask

  task automatic test_bad_ch();
    s_ch = 2'd3; s_valid = 1'b1; s_data = 32'hBADBAD00; #1;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL bad_ready got=%0b exp=1", s_ready); else n_pass++;
    step(); s_valid = 1'b0;
    n_chk++; if (err_bad_ch !== 1'b1) $display("FAIL bad_err_set got=%0b exp=1", err_bad_ch); else n_pass++;
    n_chk++; if (fifo_level !== 15'b0) $display("FAIL bad_levels got=%0h exp=0", fifo_level); else n_pass++;
    step();
    n_chk++; if (err_bad_ch !== 1'b1) $display("FAIL bad_sticky got=%0b exp=1", err_bad_ch); else n_pass++;
    err_clr = 1'b1; s_valid = 1'b1; step(); err_clr = 1'b0; s_valid = 1'b0;
    n_chk++; if (err_bad_ch !== 1'b0) $display("FAIL bad_clr_prio got=%0b exp=0", err_bad_ch); else n_pass++;
  endtask

  task automatic test_async_reset();
    push(2'd3, 32'h0);
    for (int k = 0; k < 4; k++) push(2'd0, {16'hF000 + 16'(k), 16'hE000 + 16'(k)});
    ch_vz[0] = 1'b1; step(); ch_vz[0] = 1'b0;
    n_chk++; if (lvl(0) !== 5'd4 || dat(0) !== 16'hF000) $display("FAIL ar_pre lvl=%0d data=%0h exp=4/f000", lvl(0), dat(0)); else n_pass++;
    #2 reset_n = 1'b0; #1;
    n_chk++; if (ch_lz !== 3'b0) $display("FAIL ar_lz got=%0h exp=0", ch_lz); else n_pass++;
    n_chk++; if (ch_data !== 48'b0) $display("FAIL ar_data got=%0h exp=0", ch_data); else n_pass++;
    n_chk++; if (fifo_level !== 15'b0) $display("FAIL ar_level got=%0h exp=0", fifo_level); else n_pass++;
    n_chk++; if (err_bad_ch !== 1'b0) $display("FAIL ar_err got=%0b exp=0", err_bad_ch); else n_pass++;
    #3 reset_n = 1'b1;
    step();
    push(2'd0, 32'h78785656);
    n_chk++; if (dat(0) !== 16'h5656) $display("FAIL ar_lane_reset got=%0h exp=5656", dat(0)); else n_pass++;
    clear_fifo[0] = 1'b1; step(); clear_fifo[0] = 1'b0;
  endtask

  task automatic test_sweep();
    a_data = 32'hDDCCBBAA; a_valid = 1'b1; a_vz = 1'b1; step(); a_valid = 1'b0;
    n_chk++; if (a_out !== 8'hAA) $display("FAIL sw8_l0 got=%0h exp=aa", a_out); else n_pass++;
    step();
    n_chk++; if (a_out !== 8'hBB) $display("FAIL sw8_l1 got=%0h exp=bb", a_out); else n_pass++;
    step();
    n_chk++; if (a_out !== 8'hCC) $display("FAIL sw8_l2 got=%0h exp=cc", a_out); else n_pass++;
    step();
    n_chk++; if (a_out !== 8'hDD || a_lvl !== 3'd1) $display("FAIL sw8_l3 got=%0h lvl=%0d exp=dd/1", a_out, a_lvl); else n_pass++;
    step();
    n_chk++; if (a_lz !== 1'b0 || a_lvl !== 3'd0) $display("FAIL sw8_end lz=%0b lvl=%0d exp=0/0", a_lz, a_lvl); else n_pass++;
    a_vz = 1'b0;
    b_vz = 1'b1; b_valid = 1'b1; b_data = 32'h12345678; step();
    n_chk++; if (b_out !== 32'h12345678) $display("FAIL sw32_w0 got=%0h exp=12345678", b_out); else n_pass++;
    b_data = 32'h9ABCDEF0; step(); b_valid = 1'b0;
    n_chk++; if (b_out !== 32'h9ABCDEF0 || b_lvl !== 3'd1) $display("FAIL sw32_w1 got=%0h lvl=%0d exp=9abcdef0/1", b_out, b_lvl); else n_pass++;
    step();
    n_chk++; if (b_lz !== 1'b0 || b_lvl !== 3'd0) $display("FAIL sw32_end lz=%0b lvl=%0d exp=0/0", b_lz, b_lvl); else n_pass++;
    b_vz = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_push_pop();
    test_clear();
    test_bad_ch();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dma_stream_unpacker.md
# dma_stream_unpacker

Parametrised N-channel stream unpacker between one AXI DMA read stream and the accelerator's per-channel lz/vz input ports. Each incoming DMA word carries a channel index. The block buffers the word in that channel's FIFO and serialises it into OUT_W-bit lanes, LSB lane first, on the channel's data/lz/vz handshake. It replaces the fixed one-FIFO-per-DMA instances with one configurable bank, adding per-channel clear, level reporting and bad-channel detection.

## Interface
Parameters:
- NUM_CH, 3: number of output channels (1..8).
- IN_W, 32: DMA word width. Must be an integer multiple of OUT_W.
- OUT_W, 16: channel data width.
- DEPTH, 16: words per channel FIFO. Power of two, at least 2.
- Derived: LANES = IN_W/OUT_W; CH_W = max(1, clog2(NUM_CH)); LVL_W = clog2(DEPTH)+1.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- s_data  in  IN_W  DMA word.
- s_ch  in  CH_W  destination channel of s_data.
- s_valid  in  1  DMA word valid.
- s_ready  out  1  word accepted when s_valid & s_ready on a rising edge.
- ch_data  out  NUM_CH*OUT_W  channel i occupies bits [i*OUT_W +: OUT_W].
- ch_lz  out  NUM_CH  channel i holds a valid lane.
- ch_vz  in  NUM_CH  consumer takes the lane; a transfer occurs when ch_lz[i] & ch_vz[i].
- clear_fifo  in  NUM_CH  synchronous flush of channel i.
- fifo_level  out  NUM_CH*LVL_W  words stored in channel i, in bits [i*LVL_W +: LVL_W].
- err_bad_ch  out  1  sticky flag: a word with s_ch >= NUM_CH was received.
- err_clr  in  1  synchronous clear of err_bad_ch.

## Operation
- Each channel has a DEPTH x IN_W register FIFO with a first-word-fall-through head, write/read pointers, a level counter (0..DEPTH) and a lane counter (0..LANES-1).
- s_ready is combinational and depends on s_ch:
  - If s_ch < NUM_CH: s_ready = (level[s_ch] != DEPTH) & ~clear_fifo[s_ch].
  - If s_ch >= NUM_CH: s_ready = 1. An accepted word is dropped and err_bad_ch is set.
- Push: s_valid & s_ready with a valid s_ch writes the word at wptr, increments wptr (mod DEPTH) and increments level.
- Outputs per channel:
  - ch_lz[i] = (level[i] != 0) & ~clear_fifo[i].
  - ch_data[i] = head word lane lane_cnt[i], i.e. bits [lane*OUT_W +: OUT_W]. It is forced to 0 when ch_lz[i] is low.
- Lane transfer (ch_lz[i] & ch_vz[i]):
  - If lane_cnt = LANES-1: pop the word (rptr+1, level-1) and set lane_cnt to 0.
  - Otherwise: lane_cnt+1.
  - With LANES = 1, every transfer pops.
- A push and a pop on the same channel in the same cycle leave level unchanged.
- A full FIFO refuses a push even if it pops in the same cycle.
- clear_fifo[i] high at a clock edge sets wptr, rptr, level and lane_cnt of channel i to 0. It overrides any push or pop to channel i in that cycle. Stored data is not erased. Other channels are unaffected.
- err_bad_ch: err_clr takes priority over a simultaneous set. It stays set until err_clr or reset.
- On reset_n low (asynchronous, at any time including mid-word): all pointers, levels and lane counters are 0 and err_bad_ch = 0. Hence ch_lz = 0, ch_data = 0, fifo_level = 0, and s_ready = 1 for valid s_ch while clear_fifo is low.

## Timing
- Push to visibility: a word accepted at edge t gives ch_lz = 1 and lane 0 on ch_data after edge t. This is 1 cycle of latency with no combinational path from s_data to ch_data.
- Throughput per channel is one lane per cycle. A full word drains in LANES cycles with ch_vz held high.
- fifo_level and err_bad_ch are registered and update on the edge that performs the push, pop or clear.
- s_ready has a combinational path from s_ch and clear_fifo only. It has no path from s_valid.
- The ch_vz to ch_lz/ch_data dependency takes effect only after the next edge. There are no combinational paths between channels.

## Test plan
- Reset and basic transfer, defaults: after reset all outputs are 0. Push s_data=0xBEEF1234 with s_ch=1, ch_vz=1. Next cycle: ch_lz[1]=1 and ch_data[1]=0x1234. Then 0xBEEF. Then ch_lz[1]=0 and fifo_level[1]=0.
- Full and backpressure: with ch_vz[0]=0, push 16 words to channel 0. Level is 16 and s_ready=0 for s_ch=0 while s_ch=2 still gives s_ready=1. Pop one word (2 lanes) and s_ready returns to 1. Data comes out in push order.
- Simultaneous push and pop at level 5: the level stays at 5. The lane order of the popped word is intact.
- Clear mid-word: after one of two lanes has been taken, pulse clear_fifo[2] with s_valid to channel 2 asserted. The push is refused and fifo_level[2]=0. The next pushed word starts at lane 0.
- Bad channel: NUM_CH=3, s_ch=3, s_valid=1. The word is accepted and dropped, err_bad_ch=1 and no level changes. err_clr and a bad push in the same cycle leave err_bad_ch at 0.
- Asynchronous reset mid-drain (level 4, lane 1), deasserted off-edge: all outputs return to 0 immediately. Also run a parameter sweep with IN_W=32, OUT_W=8 (4 lanes, LSB first) and with OUT_W=32 (1 lane).
